// File: rtl/sum_xfifo.sv
// sum_xfifo: inter-core partial-sum exchange FIFO with 1-cycle registered read.
// Define SUM_XFIFO_ERR_EN to implement the sticky ovf/udf error flags.
module sum_xfifo #(
    parameter int bw      = 8,
    parameter int bw_psum = 2*bw+4,
    parameter int depth   = 8,
    parameter int addr_w  = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [bw_psum+3:0]  wr_data,
    input  logic                wr_vld,
    input  logic                rd,
    output logic [bw_psum+3:0]  rd_data,
    output logic                rd_vld,
    output logic                full,
    output logic                almost_full,
    output logic                empty,
    output logic [addr_w:0]     count,
    output logic                ovf,
    output logic                udf
);
    logic [bw_psum+3:0] mem [depth];
    logic [addr_w-1:0]  wp, rp;
    logic               push, pop;

    assign full        = count == (addr_w+1)'(depth);
    assign almost_full = count >= (addr_w+1)'(depth-1);
    assign empty       = count == '0;
    assign pop         = rd && !empty;
    // at full, wp == rp: the pop reads the old word before the push overwrites it
    assign push        = wr_vld && (!full || pop);

    always_ff @(posedge clk)
        if (push) mem[wp] <= wr_data;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            wp      <= '0;
            rp      <= '0;
            count   <= '0;
            rd_data <= '0;
            rd_vld  <= 1'b0;
        end else begin
            rd_vld <= pop;
            if (pop) begin
                rd_data <= mem[rp];
                rp      <= rp + addr_w'(1);
            end
            if (push) wp <= wp + addr_w'(1);
            count <= count + (addr_w+1)'(push) - (addr_w+1)'(pop);
        end

`ifdef SUM_XFIFO_ERR_EN
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            if (wr_vld && !push) ovf <= 1'b1;
            if (rd && empty) udf <= 1'b1;
        end
`else
    assign ovf = 1'b0;
    assign udf = 1'b0;
`endif
endmodule

// File: tb/tb_sum_xfifo.sv
// tb_sum_xfifo: directed and randomized checks of sum_xfifo against a queue model.
module tb_sum_xfifo;
    localparam int depth = 8;
`ifdef SUM_XFIFO_ERR_EN
    localparam bit err_en = 1'b1;
`else
    localparam bit err_en = 1'b0;
`endif
    logic        clk = 1'b0, reset = 1'b1;
    logic [23:0] wr_data = '0;
    logic        wr_vld = 1'b0, rd = 1'b0;
    logic [23:0] rd_data;
    logic        rd_vld, full, almost_full, empty, ovf, udf;
    logic [3:0]  count;

    logic [23:0] q[$];
    logic [23:0] exp_data = '0;
    logic        exp_vld = 1'b0, exp_ovf = 1'b0, exp_udf = 1'b0;
    int          total = 0, bad = 0;

    sum_xfifo dut (
        .clk(clk), .reset(reset), .wr_data(wr_data), .wr_vld(wr_vld), .rd(rd),
        .rd_data(rd_data), .rd_vld(rd_vld), .full(full), .almost_full(almost_full),
        .empty(empty), .count(count), .ovf(ovf), .udf(udf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int sz = q.size();
        check({tag, ".rd_vld"}, 32'(rd_vld), 32'(exp_vld));
        check({tag, ".rd_data"}, 32'(rd_data), 32'(exp_data));
        check({tag, ".count"}, 32'(count), 32'(sz));
        check({tag, ".full"}, 32'(full), 32'(sz == depth));
        check({tag, ".almost_full"}, 32'(almost_full), 32'(sz >= depth-1));
        check({tag, ".empty"}, 32'(empty), 32'(sz == 0));
        check({tag, ".ovf"}, 32'(ovf), 32'(exp_ovf && err_en));
        check({tag, ".udf"}, 32'(udf), 32'(exp_udf && err_en));
    endtask

    task automatic step(input string tag, input logic wv, input logic [23:0] wd, input logic r);
        int  pre;
        bit  popped;
        wr_vld = wv;
        wr_data = wd;
        rd = r;
        @(posedge clk);
        pre = q.size();
        popped = r && pre > 0;
        exp_vld = popped;
        if (popped) exp_data = q.pop_front();
        if (wv && (pre < depth || popped)) q.push_back(wd);
        else if (wv) exp_ovf = 1'b1;
        if (r && pre == 0) exp_udf = 1'b1;
        #1;
        wr_vld = 1'b0;
        rd = 1'b0;
        check_all(tag);
    endtask

    task automatic do_reset_mid(input string tag);
        reset = 1'b1;
        #1;
        q.delete();
        exp_data = '0;
        exp_vld = 1'b0;
        exp_ovf = 1'b0;
        exp_udf = 1'b0;
        check_all(tag);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int sz;
        logic wv, r;
        #3;
        check_all("reset");
        @(negedge clk);
        reset = 1'b0;
        for (int i = 1; i <= 8; i++) step("fill", 1'b1, 24'(i), 1'b0);
        step("ovf_push", 1'b1, 24'hABCDEF, 1'b0);
        step("full_pushpop", 1'b1, 24'h000009, 1'b1);
        for (int i = 0; i < 8; i++) step("drain", 1'b0, '0, 1'b1);
        step("idle_after_drain", 1'b0, '0, 1'b0);
        step("empty_read", 1'b1, 24'h000055, 1'b1);
        step("pop_55", 1'b0, '0, 1'b1);
        step("seed_wrap", 1'b1, 24'($urandom), 1'b0);
        for (int i = 0; i < 20; i++) begin
            sz = q.size();
            wv = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            if (sz == 1 && r && !wv) wv = 1'b1;
            if (sz == 3 && wv && !r) r = 1'b1;
            step("wrap", wv, 24'($urandom), r);
        end
        for (int i = 0; i < 30; i++) step("rand", 1'($urandom_range(0, 1)), 24'($urandom), 1'($urandom_range(0, 1)));
        step("pre_reset_push", 1'b1, 24'h123456, 1'b0);
        wr_vld = 1'b1;
        wr_data = 24'h777777;
        rd = 1'b1;
        @(posedge clk);
        #2;
        do_reset_mid("reset_mid");
        wr_vld = 1'b0;
        rd = 1'b0;
        step("post_reset_idle", 1'b0, '0, 1'b0);
        step("post_reset_push", 1'b1, 24'h0000AA, 1'b0);
        step("post_reset_pop", 1'b0, '0, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
